// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: bus-wait stalls, redirect flushes, load-use
// bubbles, CSR drain bubbles, operand forwarding selects and a stall counter.
module pipe_hazard_ctrl #(
  parameter int unsigned CSR_DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  // decode side
  input  logic        rs1ReadEnableD,
  input  logic [4:0]  rs1ReadAddrD,
  input  logic        rs2ReadEnableD,
  input  logic [4:0]  rs2ReadAddrD,
  input  logic        csrReadEnableD,
  // execute side
  input  logic        rdWriteEnableE,
  input  logic [4:0]  rdWriteAddrE,
  input  logic        BusReadEnableE,
  input  logic        csrE,
  input  logic        redirectE,
  // memory side
  input  logic        rdWriteEnableM,
  input  logic [4:0]  rdWriteAddrM,
  input  logic        memReqM,
  input  logic        busReadyM,
  // pipeline control
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        stallM,
  output logic        flushF,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic [1:0]  fwdASelD,
  output logic [1:0]  fwdBSelD,
  output logic [31:0] stallCycles
);

  localparam int unsigned CNT_W = (CSR_DRAIN_CYCLES < 2) ? 1 : $clog2(CSR_DRAIN_CYCLES + 1);
  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_CSR_DRAIN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  // Mode to resume once the bus wait completes (RUN or CSR_DRAIN)
  state_t           r_ret;
  state_t           w_ret_nxt;
  state_t           w_mode;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_redir_pend;
  logic             w_redir_pend_nxt;
  logic [31:0]      r_stall_cycles;

  logic             w_bus_stall;
  logic             w_redirect;
  logic             w_load_use;
  logic             w_csr_go;
  logic             w_e_writes;
  logic [1:0]       w_fwd_a;
  logic [1:0]       w_fwd_b;

  // A wait already in progress ends the cycle the handshake completes;
  // that cycle is treated as an ordinary cycle of the resumed mode.
  assign w_bus_stall = (r_state == ST_MEM_WAIT) ? !busReadyM : (memReqM && !busReadyM);
  assign w_mode      = (r_state == ST_MEM_WAIT) ? r_ret : r_state;
  assign w_redirect  = redirectE || r_redir_pend;
  assign w_e_writes  = rdWriteEnableE && (rdWriteAddrE != 5'd0);
  assign w_load_use  = BusReadEnableE && w_e_writes &&
                       ((rs1ReadEnableD && (rs1ReadAddrD == rdWriteAddrE)) ||
                        (rs2ReadEnableD && (rs2ReadAddrD == rdWriteAddrE)));
  assign w_csr_go    = csrE && csrReadEnableD && (CSR_DRAIN_CYCLES != 0);

  // Forwarding selects: E result beats M result; loads in E never forward, x0 never forwards
  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (rs1ReadEnableD && (rs1ReadAddrD != 5'd0) && rdWriteEnableE && !BusReadEnableE &&
        (rdWriteAddrE == rs1ReadAddrD)) begin
      w_fwd_a = 2'b01;
    end else if (rdWriteEnableM && (rdWriteAddrM != 5'd0) && (rdWriteAddrM == rs1ReadAddrD)) begin
      w_fwd_a = 2'b10;
    end
    if (rs2ReadEnableD && (rs2ReadAddrD != 5'd0) && rdWriteEnableE && !BusReadEnableE &&
        (rdWriteAddrE == rs2ReadAddrD)) begin
      w_fwd_b = 2'b01;
    end else if (rdWriteEnableM && (rdWriteAddrM != 5'd0) && (rdWriteAddrM == rs2ReadAddrD)) begin
      w_fwd_b = 2'b10;
    end
  end

  // Next-state and stall/flush/forward outputs
  always_comb begin
    w_state_nxt      = r_state;
    w_ret_nxt        = r_ret;
    w_cnt_nxt        = r_cnt;
    w_redir_pend_nxt = r_redir_pend;
    stallF           = 1'b0;
    stallD           = 1'b0;
    stallE           = 1'b0;
    stallM           = 1'b0;
    flushF           = 1'b0;
    flushD           = 1'b0;
    flushE           = 1'b0;
    flushM           = 1'b0;
    fwdASelD         = 2'b00;
    fwdBSelD         = 2'b00;

    if (rst) begin
      flushF = 1'b1;
      flushD = 1'b1;
      flushE = 1'b1;
      flushM = 1'b1;
    end else begin
      fwdASelD = w_fwd_a;
      fwdBSelD = w_fwd_b;
      if (w_bus_stall) begin
        // Freeze everything, bubble into W; a redirect seen now is owed later
        stallF           = 1'b1;
        stallD           = 1'b1;
        stallE           = 1'b1;
        stallM           = 1'b1;
        flushM           = 1'b1;
        w_state_nxt      = ST_MEM_WAIT;
        w_redir_pend_nxt = r_redir_pend || redirectE;
        if (r_state != ST_MEM_WAIT) begin
          w_ret_nxt = r_state;
        end
      end else begin
        w_redir_pend_nxt = 1'b0;
        w_ret_nxt        = ST_RUN;
        if (w_redirect) begin
          flushF      = 1'b1;
          flushD      = 1'b1;
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else if (w_mode == ST_CSR_DRAIN) begin
          stallF      = 1'b1;
          flushD      = 1'b1;
          w_cnt_nxt   = r_cnt - CNT_W'(1);
          w_state_nxt = (r_cnt <= CNT_W'(1)) ? ST_RUN : ST_CSR_DRAIN;
        end else begin
          w_state_nxt = ST_RUN;
          if (w_load_use) begin
            stallF = 1'b1;
            flushD = 1'b1;
          end
          if (w_csr_go) begin
            w_state_nxt = ST_CSR_DRAIN;
            w_cnt_nxt   = CNT_W'(CSR_DRAIN_CYCLES);
          end
        end
      end
    end
  end

  // State, drain counter and owed-redirect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_RUN;
      r_ret        <= ST_RUN;
      r_cnt        <= '0;
      r_redir_pend <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ret        <= w_ret_nxt;
      r_cnt        <= w_cnt_nxt;
      r_redir_pend <= w_redir_pend_nxt;
    end
  end

  // Saturating count of fetch-stall cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (stallF && (r_stall_cycles != STALL_MAX)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stallCycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed vector table, hand-written
// multi-cycle sequences, then random stimulus against a behavioural model.
module tb_pipe_hazard_ctrl;

  localparam int unsigned CSR_N = 2;

  typedef struct packed {
    logic       rs1e;
    logic [4:0] rs1;
    logic       rs2e;
    logic [4:0] rs2;
    logic       csrd;
    logic       rdwe_e;
    logic [4:0] rd_e;
    logic       ld_e;
    logic       csr_e;
    logic       redir;
    logic       rdwe_m;
    logic [4:0] rd_m;
    logic       memreq;
    logic       ready;
  } in_t;

  typedef struct {
    in_t        vin;
    logic [11:0] exp;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        rs1ReadEnableD, rs2ReadEnableD, csrReadEnableD;
  logic [4:0]  rs1ReadAddrD, rs2ReadAddrD;
  logic        rdWriteEnableE, BusReadEnableE, csrE, redirectE;
  logic [4:0]  rdWriteAddrE;
  logic        rdWriteEnableM, memReqM, busReadyM;
  logic [4:0]  rdWriteAddrM;
  logic        stallF, stallD, stallE, stallM;
  logic        flushF, flushD, flushE, flushM;
  logic [1:0]  fwdASelD, fwdBSelD;
  logic [31:0] stallCycles;

  int errs;
  int checks;

  // Model state: bus wait in progress, drain bubbles left, owed redirect, stall count
  bit          m_wait;
  int          m_drain;
  bit          m_owed;
  logic [31:0] m_cnt;

  pipe_hazard_ctrl #(.CSR_DRAIN_CYCLES(CSR_N)) dut (
    .clk(clk), .rst(rst),
    .rs1ReadEnableD(rs1ReadEnableD), .rs1ReadAddrD(rs1ReadAddrD),
    .rs2ReadEnableD(rs2ReadEnableD), .rs2ReadAddrD(rs2ReadAddrD),
    .csrReadEnableD(csrReadEnableD),
    .rdWriteEnableE(rdWriteEnableE), .rdWriteAddrE(rdWriteAddrE),
    .BusReadEnableE(BusReadEnableE), .csrE(csrE), .redirectE(redirectE),
    .rdWriteEnableM(rdWriteEnableM), .rdWriteAddrM(rdWriteAddrM),
    .memReqM(memReqM), .busReadyM(busReadyM),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM),
    .fwdASelD(fwdASelD), .fwdBSelD(fwdBSelD), .stallCycles(stallCycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input in_t v, input logic r);
    rst            = r;
    rs1ReadEnableD = v.rs1e;   rs1ReadAddrD = v.rs1;
    rs2ReadEnableD = v.rs2e;   rs2ReadAddrD = v.rs2;
    csrReadEnableD = v.csrd;
    rdWriteEnableE = v.rdwe_e; rdWriteAddrE = v.rd_e;
    BusReadEnableE = v.ld_e;   csrE = v.csr_e; redirectE = v.redir;
    rdWriteEnableM = v.rdwe_m; rdWriteAddrM = v.rd_m;
    memReqM        = v.memreq; busReadyM = v.ready;
  endtask

  function automatic logic [1:0] fwd_ref(input logic en, input logic [4:0] a, input in_t v);
    if (a == 5'd0) return 2'b00;
    if (en && v.rdwe_e && !v.ld_e && v.rd_e == a) return 2'b01;
    if (v.rdwe_m && v.rd_m == a) return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit load_use_ref(input in_t v);
    if (!(v.ld_e && v.rdwe_e) || v.rd_e == 5'd0) return 1'b0;
    return (v.rs1e && v.rs1 == v.rd_e) || (v.rs2e && v.rs2 == v.rd_e);
  endfunction

  // One cycle of the behavioural model; returns expected {stalls, flushes, fwdA, fwdB}
  task automatic model_step(input in_t v, input logic r, output logic [11:0] e);
    logic [3:0] st, fl;
    logic [1:0] fa, fb;
    bit bus, rd;
    st = 4'b0000; fl = 4'b0000; fa = 2'b00; fb = 2'b00;
    if (r) begin
      fl = 4'b1111;
      m_wait = 0; m_drain = 0; m_owed = 0; m_cnt = 32'd0;
    end else begin
      fa  = fwd_ref(v.rs1e, v.rs1, v);
      fb  = fwd_ref(v.rs2e, v.rs2, v);
      bus = m_wait ? !v.ready : (v.memreq && !v.ready);
      if (bus) begin
        st = 4'b1111; fl = 4'b0001;
        m_owed = m_owed || v.redir;
        m_wait = 1;
      end else begin
        m_wait = 0;
        rd = v.redir || m_owed;
        m_owed = 0;
        if (rd) begin
          fl = 4'b1100; m_drain = 0;
        end else if (m_drain > 0) begin
          st = 4'b1000; fl = 4'b0100; m_drain--;
        end else begin
          if (load_use_ref(v)) begin st = 4'b1000; fl = 4'b0100; end
          if (v.csr_e && v.csrd) m_drain = CSR_N;
        end
      end
      if (st[3] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    e = {st, fl, fa, fb};
  endtask

  // Apply one cycle; compare against the given constant or the model
  task automatic step(input in_t v, input logic r, input logic [11:0] exp,
                      input bit use_model, input string name);
    logic [11:0] me, act, want;
    logic [31:0] cnt_want;
    drive(v, r);
    @(negedge clk);
    cnt_want = m_cnt;
    model_step(v, r, me);
    act  = {stallF, stallD, stallE, stallM, flushF, flushD, flushE, flushM, fwdASelD, fwdBSelD};
    want = use_model ? me : exp;
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s outputs: got %b want %b", name, act, want);
    end
    checks++;
    if (stallCycles !== cnt_want) begin
      errs++;
      $display("FAIL %s stallCycles: got %0d want %0d", name, stallCycles, cnt_want);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input logic [31:0] want, input string name);
    checks++;
    if (stallCycles !== want) begin
      errs++;
      $display("FAIL %s stallCycles: got %0d want %0d", name, stallCycles, want);
    end
  endtask

  localparam logic [11:0] E_IDLE  = 12'b0000_0000_00_00;
  localparam logic [11:0] E_RST   = 12'b0000_1111_00_00;
  localparam logic [11:0] E_BUB   = 12'b1000_0100_00_00;
  localparam logic [11:0] E_BUS   = 12'b1111_0001_00_00;
  localparam logic [11:0] E_REDIR = 12'b0000_1100_00_00;

  vec_t tbl[13];
  in_t  v;
  in_t  idle;

  initial begin
    errs = 0; checks = 0;
    m_wait = 0; m_drain = 0; m_owed = 0; m_cnt = 32'd0;
    idle = '0;
    drive(idle, 1'b1);
    @(posedge clk); #1;

    tbl[0]  = '{idle, E_IDLE};
    tbl[1]  = '{in_t'{rs1e:1'b1, rs1:5'd5, rdwe_e:1'b1, rd_e:5'd5, ld_e:1'b1, default:'0}, E_BUB};
    tbl[2]  = '{in_t'{rs1:5'd5, rs2e:1'b1, rs2:5'd5, rdwe_e:1'b1, rd_e:5'd5, ld_e:1'b1, default:'0}, E_BUB};
    tbl[3]  = '{in_t'{rs1:5'd5, rs2e:1'b1, rs2:5'd6, rdwe_e:1'b1, rd_e:5'd5, ld_e:1'b1, default:'0}, E_IDLE};
    tbl[4]  = '{in_t'{rs1e:1'b1, rdwe_e:1'b1, ld_e:1'b1, default:'0}, E_IDLE};
    tbl[5]  = '{in_t'{rs1e:1'b1, rs1:5'd7, rs2e:1'b1, rs2:5'd7, rdwe_e:1'b1, rd_e:5'd7,
                      rdwe_m:1'b1, rd_m:5'd7, default:'0}, 12'b0000_0000_01_01};
    tbl[6]  = '{in_t'{rs1e:1'b1, rs2e:1'b1, rdwe_e:1'b1, rdwe_m:1'b1, default:'0}, E_IDLE};
    tbl[7]  = '{in_t'{rs1e:1'b1, rs1:5'd3, rs2e:1'b1, rs2:5'd4, rdwe_e:1'b1, rd_e:5'd4,
                      rdwe_m:1'b1, rd_m:5'd3, default:'0}, 12'b0000_0000_10_01};
    tbl[8]  = '{in_t'{rs1e:1'b1, rs1:5'd5, rdwe_e:1'b1, rd_e:5'd5, ld_e:1'b1, redir:1'b1, default:'0}, E_REDIR};
    tbl[9]  = '{in_t'{memreq:1'b1, default:'0}, E_BUS};
    tbl[10] = '{in_t'{memreq:1'b1, redir:1'b1, default:'0}, E_BUS};
    tbl[11] = '{in_t'{memreq:1'b1, ready:1'b1, default:'0}, E_IDLE};
    tbl[12] = '{in_t'{csr_e:1'b1, csrd:1'b1, default:'0}, E_IDLE};

    // Single-cycle vectors, each from a freshly reset controller
    for (int i = 0; i < 13; i++) begin
      step(idle, 1'b1, E_RST, 1'b0, $sformatf("tbl%0d_rst", i));
      step(tbl[i].vin, 1'b0, tbl[i].exp, 1'b0, $sformatf("tbl%0d", i));
    end

    // Load-use bubble, then M forwarding
    step(idle, 1'b1, E_RST, 1'b0, "lu_rst");
    step(tbl[1].vin, 1'b0, E_BUB, 1'b0, "lu_bubble");
    v = '{rs1e:1'b1, rs1:5'd5, rdwe_m:1'b1, rd_m:5'd5, default:'0};
    step(v, 1'b0, 12'b0000_0000_10_00, 1'b0, "lu_fwd_m");

    // Bus wait of 3 cycles
    step(idle, 1'b1, E_RST, 1'b0, "bus_rst");
    chk_cnt(32'd0, "bus_cnt0");
    v = '{memreq:1'b1, default:'0};
    for (int i = 0; i < 3; i++) step(v, 1'b0, E_BUS, 1'b0, $sformatf("bus_wait%0d", i));
    v.ready = 1'b1;
    step(v, 1'b0, E_IDLE, 1'b0, "bus_done");
    chk_cnt(32'd3, "bus_cnt3");
    step(idle, 1'b0, E_IDLE, 1'b0, "bus_run");

    // CSR drain: two bubbles
    step(idle, 1'b1, E_RST, 1'b0, "csr_rst");
    step(tbl[12].vin, 1'b0, E_IDLE, 1'b0, "csr_enter");
    step(idle, 1'b0, E_BUB, 1'b0, "csr_drain0");
    step(idle, 1'b0, E_BUB, 1'b0, "csr_drain1");
    step(idle, 1'b0, E_IDLE, 1'b0, "csr_done");
    chk_cnt(32'd2, "csr_cnt");

    // CSR drain interrupted by a 2-cycle bus stall
    step(idle, 1'b1, E_RST, 1'b0, "csrbus_rst");
    step(tbl[12].vin, 1'b0, E_IDLE, 1'b0, "csrbus_enter");
    step(idle, 1'b0, E_BUB, 1'b0, "csrbus_drain0");
    step(tbl[9].vin, 1'b0, E_BUS, 1'b0, "csrbus_wait0");
    step(idle, 1'b0, E_BUS, 1'b0, "csrbus_wait1");
    v = '{ready:1'b1, default:'0};
    step(v, 1'b0, E_BUB, 1'b0, "csrbus_drain1");
    step(idle, 1'b0, E_IDLE, 1'b0, "csrbus_done");
    chk_cnt(32'd4, "csrbus_cnt");

    // Redirect arriving during a bus stall is applied afterwards
    step(idle, 1'b1, E_RST, 1'b0, "rdh_rst");
    step(tbl[10].vin, 1'b0, E_BUS, 1'b0, "rdh_stall");
    v = '{ready:1'b1, default:'0};
    step(v, 1'b0, E_REDIR, 1'b0, "rdh_apply");
    step(idle, 1'b0, E_IDLE, 1'b0, "rdh_clear");

    // Reset in the middle of a bus wait
    step(idle, 1'b1, E_RST, 1'b0, "rmw_rst0");
    step(tbl[9].vin, 1'b0, E_BUS, 1'b0, "rmw_wait0");
    step(idle, 1'b0, E_BUS, 1'b0, "rmw_wait1");
    step(idle, 1'b1, E_RST, 1'b0, "rmw_rst");
    chk_cnt(32'd0, "rmw_cnt");
    step(idle, 1'b0, E_IDLE, 1'b0, "rmw_run");

    // Random stimulus against the model
    step(idle, 1'b1, E_RST, 1'b0, "rnd_rst");
    for (int n = 0; n < 3000; n++) begin
      v.rs1e   = 1'($urandom_range(0, 1));
      v.rs1    = 5'($urandom_range(0, 3));
      v.rs2e   = 1'($urandom_range(0, 1));
      v.rs2    = 5'($urandom_range(0, 3));
      v.csrd   = 1'($urandom_range(0, 1));
      v.rdwe_e = 1'($urandom_range(0, 1));
      v.rd_e   = 5'($urandom_range(0, 3));
      v.ld_e   = ($urandom_range(0, 2) == 0);
      v.csr_e  = ($urandom_range(0, 3) == 0);
      v.redir  = ($urandom_range(0, 7) == 0);
      v.rdwe_m = 1'($urandom_range(0, 1));
      v.rd_m   = 5'($urandom_range(0, 3));
      v.memreq = ($urandom_range(0, 2) == 0);
      v.ready  = 1'($urandom_range(0, 1));
      step(v, ($urandom_range(0, 99) == 0), E_IDLE, 1'b1, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
